run_sequencer: RTL and testbench

Program-run sequencer that sits between the testbench and the core: top_level, PC, reg_file and data_mem. It accepts a start request with a program number and holds the core in reset while loading that program's start address into the PC. It then releases the core, counts execution cycles and detects completion from the control decoder's Ack, with a watchdog timeout. It also arbitrates the single data_mem write port between testbench preload/readback and the running core.

---
 rtl/run_sequencer_if.sv | 56 +++++
 rtl/run_sequencer.sv | 145 ++++++++++++++
 tb/tb_run_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/run_sequencer_if.sv
// run_sequencer_if
//   Groups every signal that run_sequencer exchanges with the testbench and
//   the core (start/complete handshake, watchdog, PC init, both data_mem
//   write sources and the muxed data_mem write port).
//   Modports:
//     slave  - the sequencer: samples requests and core signals, drives
//              core control, status and the muxed data_mem port.
//     master - the environment (testbench + core): the mirror image.
//   Parameters: PC_W (start-address width), DM_AW (data_mem address width).
interface run_sequencer_if #(
    parameter int PC_W  = 10,
    parameter int DM_AW = 8
);
    // testbench control / status
    logic              req;
    logic [1:0]        prog_sel;
    logic [15:0]       timeout_cycles;
    logic              ack;
    logic              timeout;
    logic [15:0]       cycle_count;

    // core control
    logic              core_ack;
    logic              core_reset;
    logic [PC_W-1:0]   pc_init;

    // data_mem write sources
    logic              core_mem_wr_en;
    logic [DM_AW-1:0]  core_mem_addr;
    logic [7:0]        core_mem_data;
    logic              tb_mem_wr_en;
    logic [DM_AW-1:0]  tb_mem_addr;
    logic [7:0]        tb_mem_data;

    // muxed data_mem write port
    logic              mem_owner;
    logic              dm_wr_en;
    logic [DM_AW-1:0]  dm_addr;
    logic [7:0]        dm_data;

    modport slave (
        input  req, prog_sel, timeout_cycles, core_ack,
        input  core_mem_wr_en, core_mem_addr, core_mem_data,
        input  tb_mem_wr_en, tb_mem_addr, tb_mem_data,
        output ack, timeout, cycle_count, core_reset, pc_init,
        output mem_owner, dm_wr_en, dm_addr, dm_data
    );

    modport master (
        output req, prog_sel, timeout_cycles, core_ack,
        output core_mem_wr_en, core_mem_addr, core_mem_data,
        output tb_mem_wr_en, tb_mem_addr, tb_mem_data,
        input  ack, timeout, cycle_count, core_reset, pc_init,
        input  mem_owner, dm_wr_en, dm_addr, dm_data
    );
endinterface

// File: rtl/run_sequencer.sv
// run_sequencer
//   Sequences one program run of the core: on a rising edge of req with a
//   valid prog_sel it holds the core in reset for two cycles while presenting
//   the program's start address on pc_init, then releases the core, counts
//   run cycles (saturating) and finishes on core_ack or on the watchdog.
//   While running, the core owns the data_mem write port; otherwise the
//   testbench owns it.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous, active-low reset
//     bus   - run_sequencer_if.slave (handshake, core control, memory ports)
module run_sequencer #(
    parameter int              PC_W         = 10,
    parameter logic [PC_W-1:0] START_ADDR_1 = '0,
    parameter logic [PC_W-1:0] START_ADDR_2 = '0,
    parameter logic [PC_W-1:0] START_ADDR_3 = '0,
    parameter int              DM_AW        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    run_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_reg,       state_next;
    logic            load_cnt_reg,    load_cnt_next;
    logic            req_q_reg;
    logic [1:0]      prog_reg,        prog_next;
    logic [15:0]     cycle_count_reg, cycle_count_next;
    logic            timeout_reg,     timeout_next;
    logic [PC_W-1:0] pc_init_reg,     pc_init_next;

    logic            req_rise;
    logic [16:0]     cycle_inc;
    logic            watchdog_hit;

    function automatic logic [PC_W-1:0] start_addr(input logic [1:0] n);
        case (n)
            2'd1:    start_addr = START_ADDR_1;
            2'd2:    start_addr = START_ADDR_2;
            2'd3:    start_addr = START_ADDR_3;
            default: start_addr = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            load_cnt_reg    <= 1'b0;
            req_q_reg       <= 1'b0;
            prog_reg        <= 2'd0;
            cycle_count_reg <= 16'd0;
            timeout_reg     <= 1'b0;
            pc_init_reg     <= '0;
        end else begin
            state_reg       <= state_next;
            load_cnt_reg    <= load_cnt_next;
            req_q_reg       <= bus.req;
            prog_reg        <= prog_next;
            cycle_count_reg <= cycle_count_next;
            timeout_reg     <= timeout_next;
            pc_init_reg     <= pc_init_next;
        end
    end

    assign req_rise  = bus.req & ~req_q_reg;
    // 17 bits so a saturated count never wraps into a false watchdog match
    assign cycle_inc = {1'b0, cycle_count_reg} + 17'd1;
    assign watchdog_hit = (bus.timeout_cycles != 16'd0) &&
                          (cycle_inc == {1'b0, bus.timeout_cycles});

    always_comb begin
        state_next       = state_reg;
        load_cnt_next    = load_cnt_reg;
        prog_next        = prog_reg;
        cycle_count_next = cycle_count_reg;
        timeout_next     = timeout_reg;
        pc_init_next     = pc_init_reg;

        case (state_reg)
            ST_IDLE: begin
                // A rising edge with prog_sel=0 is consumed here: req_q
                // follows req, so only a fresh rising edge can start a run.
                if (req_rise && (bus.prog_sel != 2'd0)) begin
                    state_next       = ST_LOAD;
                    load_cnt_next    = 1'b0;
                    prog_next        = bus.prog_sel;
                    // Loaded on entry so pc_init is valid for both LOAD cycles
                    pc_init_next     = start_addr(bus.prog_sel);
                    cycle_count_next = 16'd0;
                    timeout_next     = 1'b0;
                end
            end
            ST_LOAD: begin
                pc_init_next = start_addr(prog_reg);
                if (load_cnt_reg) begin
                    state_next    = ST_RUN;
                    load_cnt_next = 1'b0;
                end else begin
                    load_cnt_next = 1'b1;
                end
            end
            ST_RUN: begin
                if (cycle_count_reg != 16'hFFFF) begin
                    cycle_count_next = cycle_inc[15:0];
                end
                // core_ack takes priority over a same-edge watchdog expiry
                if (bus.core_ack) begin
                    state_next = ST_DONE;
                end else if (watchdog_hit) begin
                    state_next   = ST_DONE;
                    timeout_next = 1'b1;
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so an async reset clears them at once
    assign bus.core_reset  = (state_reg != ST_RUN);
    assign bus.mem_owner   = (state_reg == ST_RUN);
    assign bus.ack         = (state_reg == ST_DONE);
    assign bus.timeout     = timeout_reg;
    assign bus.cycle_count = cycle_count_reg;
    assign bus.pc_init     = pc_init_reg;

    // Write-port arbitration: only the current owner's write reaches data_mem
    assign bus.dm_wr_en = bus.mem_owner ? bus.core_mem_wr_en : bus.tb_mem_wr_en;
    assign bus.dm_addr  = bus.mem_owner ? bus.core_mem_addr  : bus.tb_mem_addr;
    assign bus.dm_data  = bus.mem_owner ? bus.core_mem_data  : bus.tb_mem_data;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

    localparam int              PC_W  = 10;
    localparam int              DM_AW = 8;
    localparam logic [PC_W-1:0] SA1   = 10'h011;
    localparam logic [PC_W-1:0] SA2   = 10'h040;
    localparam logic [PC_W-1:0] SA3   = 10'h123;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    run_sequencer_if #(.PC_W(PC_W), .DM_AW(DM_AW)) bus ();

    run_sequencer #(
        .PC_W         (PC_W),
        .START_ADDR_1 (SA1),
        .START_ADDR_2 (SA2),
        .START_ADDR_3 (SA3),
        .DM_AW        (DM_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // rising edge of req; returns just after the edge that enters RUN
    task automatic start_run(input logic [1:0] sel);
        bus.req      = 1'b0;
        tick();
        bus.prog_sel = sel;
        bus.req      = 1'b1;
        ticks(3);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.req            = 1'b0;
        bus.prog_sel       = 2'd0;
        bus.timeout_cycles = 16'd0;
        bus.core_ack       = 1'b0;
        bus.core_mem_wr_en = 1'b0;
        bus.core_mem_addr  = '0;
        bus.core_mem_data  = 8'h00;
        bus.tb_mem_wr_en   = 1'b0;
        bus.tb_mem_addr    = '0;
        bus.tb_mem_data    = 8'h00;

        #12;
        check("rst_core_reset", 32'(bus.core_reset), 32'd1);
        check("rst_ack",        32'(bus.ack),        32'd0);
        check("rst_pc_init",    32'(bus.pc_init),    32'd0);
        check("rst_mem_owner",  32'(bus.mem_owner),  32'd0);
        rst_n = 1'b1;
        ticks(2);

        // arbitration in IDLE: testbench owns the port
        bus.tb_mem_wr_en = 1'b1; bus.tb_mem_addr = 8'd3; bus.tb_mem_data = 8'hA5;
        #1;
        check("idle_dm_wr_en", 32'(bus.dm_wr_en), 32'd1);
        check("idle_dm_addr",  32'(bus.dm_addr),  32'd3);
        check("idle_dm_data",  32'(bus.dm_data),  32'hA5);
        bus.tb_mem_wr_en = 1'b0;

        // prog_sel=0 request is dropped; holding req high then fixing sel does not start
        bus.prog_sel = 2'd0; bus.req = 1'b1;
        ticks(2);
        check("sel0_core_reset", 32'(bus.core_reset), 32'd1);
        check("sel0_pc_init",    32'(bus.pc_init),    32'd0);
        bus.prog_sel = 2'd2;
        ticks(4);
        check("sel0_no_start_pc", 32'(bus.pc_init),   32'd0);
        check("sel0_no_start_rst", 32'(bus.core_reset), 32'd1);
        bus.req = 1'b0;
        tick();

        // normal run, program 2, core_ack on the 10th RUN edge
        bus.prog_sel = 2'd2; bus.req = 1'b1;
        tick();                                         // edge E
        check("load1_pc_init",    32'(bus.pc_init),    32'h040);
        check("load1_core_reset", 32'(bus.core_reset), 32'd1);
        bus.core_ack = 1'b1;                            // ignored in LOAD
        tick();                                         // E+1
        check("load2_pc_init",    32'(bus.pc_init),    32'h040);
        check("load2_core_reset", 32'(bus.core_reset), 32'd1);
        tick();                                         // E+2 -> RUN
        bus.core_ack = 1'b0;
        check("run_core_reset", 32'(bus.core_reset), 32'd0);
        check("run_mem_owner",  32'(bus.mem_owner),  32'd1);
        check("run_count0",     32'(bus.cycle_count), 32'd0);
        // arbitration in RUN
        bus.tb_mem_wr_en = 1'b1; bus.tb_mem_addr = 8'd9;
        #1;
        check("run_tb_dropped", 32'(bus.dm_wr_en), 32'd0);
        bus.core_mem_wr_en = 1'b1; bus.core_mem_addr = 8'd7; bus.core_mem_data = 8'h3C;
        #1;
        check("run_core_wr_en", 32'(bus.dm_wr_en), 32'd1);
        check("run_core_addr",  32'(bus.dm_addr),  32'd7);
        check("run_core_data",  32'(bus.dm_data),  32'h3C);
        bus.tb_mem_wr_en = 1'b0; bus.core_mem_wr_en = 1'b0;
        ticks(9);
        check("run_count9", 32'(bus.cycle_count), 32'd9);
        check("run_ack_low", 32'(bus.ack), 32'd0);
        bus.core_ack = 1'b1;
        tick();
        bus.core_ack = 1'b0;
        check("done_ack",        32'(bus.ack),         32'd1);
        check("done_count",      32'(bus.cycle_count), 32'd10);
        check("done_timeout",    32'(bus.timeout),     32'd0);
        check("done_core_reset", 32'(bus.core_reset),  32'd1);
        bus.core_mem_wr_en = 1'b1;
        #1;
        check("done_core_wr_dropped", 32'(bus.dm_wr_en), 32'd0);
        bus.core_mem_wr_en = 1'b0;
        bus.req = 1'b0;
        tick();
        check("idle_ack_low", 32'(bus.ack), 32'd0);

        // watchdog after 5 RUN edges
        bus.timeout_cycles = 16'd5;
        start_run(2'd1);
        check("wd_pc_init", 32'(bus.pc_init), 32'h011);
        ticks(4);
        check("wd_still_run", 32'(bus.core_reset), 32'd0);
        tick();
        check("wd_ack",     32'(bus.ack),         32'd1);
        check("wd_timeout", 32'(bus.timeout),     32'd1);
        check("wd_count",   32'(bus.cycle_count), 32'd5);
        // req held high through DONE: no restart, status holds
        ticks(5);
        check("hold_ack",     32'(bus.ack),         32'd1);
        check("hold_timeout", 32'(bus.timeout),     32'd1);
        check("hold_count",   32'(bus.cycle_count), 32'd5);
        // req falls then rises with prog_sel=1: status cleared on LOAD entry
        bus.req = 1'b0;
        tick();
        bus.prog_sel = 2'd1; bus.req = 1'b1;
        bus.timeout_cycles = 16'd0;
        tick();
        check("rerun_timeout_clr", 32'(bus.timeout),     32'd0);
        check("rerun_count_clr",   32'(bus.cycle_count), 32'd0);
        ticks(2);
        bus.core_ack = 1'b1;
        tick();
        bus.core_ack = 1'b0;
        check("rerun_count1", 32'(bus.cycle_count), 32'd1);
        bus.req = 1'b0;
        tick();

        // core_ack and watchdog on the same edge: core_ack wins
        bus.timeout_cycles = 16'd5;
        start_run(2'd3);
        check("sim_pc_init", 32'(bus.pc_init), 32'h123);
        ticks(4);
        bus.core_ack = 1'b1;
        tick();
        bus.core_ack = 1'b0;
        check("sim_ack",     32'(bus.ack),         32'd1);
        check("sim_timeout", 32'(bus.timeout),     32'd0);
        check("sim_count",   32'(bus.cycle_count), 32'd5);
        bus.req = 1'b0;
        tick();

        // watchdog disabled: count saturates and the run continues
        bus.timeout_cycles = 16'd0;
        start_run(2'd2);
        ticks(66000);
        check("sat_count",      32'(bus.cycle_count), 32'hFFFF);
        check("sat_still_run",  32'(bus.core_reset),  32'd0);

        // asynchronous reset mid-run, no clock edge in between
        rst_n = 1'b0;
        #2;
        check("arst_core_reset", 32'(bus.core_reset),  32'd1);
        check("arst_ack",        32'(bus.ack),         32'd0);
        check("arst_timeout",    32'(bus.timeout),     32'd0);
        check("arst_count",      32'(bus.cycle_count), 32'd0);
        check("arst_mem_owner",  32'(bus.mem_owner),   32'd0);
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
